// File: rtl/bus_cycle_controller_if.sv
// CPU-side bus bundle for the Mackerel 68030 bus-cycle controller.
//   master : CPU/bus side, drives address, strobes and external acknowledges
//   slave  : controller side, drives cycle termination and the decoded strobes
// Signals:
//   A[31:0], FC[2:0], AS_n, DS_n, RW  CPU address, function code, strobes, direction
//   EXT_DSACK_n[1:0]                  {DSACK1,DSACK0} from external-ack responders
//   DSACK0_n, DSACK1_n, BERR_n        cycle termination
//   AVEC_n                            autovector request
//   RD_n, WR_n                        combinational read/write strobes
interface bus_cycle_controller_if;
  logic [31:0] A;
  logic [2:0]  FC;
  logic        AS_n;
  logic        DS_n;
  logic        RW;
  logic [1:0]  EXT_DSACK_n;
  logic        DSACK0_n;
  logic        DSACK1_n;
  logic        BERR_n;
  logic        AVEC_n;
  logic        RD_n;
  logic        WR_n;

  modport master (
    output A, FC, AS_n, DS_n, RW, EXT_DSACK_n,
    input  DSACK0_n, DSACK1_n, BERR_n, AVEC_n, RD_n, WR_n
  );

  modport slave (
    input  A, FC, AS_n, DS_n, RW, EXT_DSACK_n,
    output DSACK0_n, DSACK1_n, BERR_n, AVEC_n, RD_n, WR_n
  );
endinterface

// File: rtl/bus_cycle_controller.sv
// Registered bus-cycle controller for the 68030 Mackerel boards.
// Decodes NUM_REGIONS address windows (region 0 = boot ROM) with per-region
// wait states and port width, runs a boot-ROM overlay for the first
// BOOT_CYCLES bus cycles, terminates stalled cycles with BERR, and handles
// interrupt priority encoding plus vectored/autovectored IACK.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   bus        CPU bus bundle (slave side)
//   IRQ[6:0]   active-high interrupt requests, bit L-1 = level L
//   CS_n       registered chip selects, one per region
//   IACK_n     registered per-level interrupt acknowledge
//   IPL_n      registered, inverted highest pending level
//   BOOT       0 while the boot overlay is active
module bus_cycle_controller #(
  parameter int unsigned                NUM_REGIONS   = 4,
  parameter logic [NUM_REGIONS*16-1:0]  REGION_BASE   = '0,
  parameter logic [NUM_REGIONS*16-1:0]  REGION_MASK   = '0,
  parameter logic [NUM_REGIONS*4-1:0]   REGION_WAIT   = '0,
  parameter logic [NUM_REGIONS*2-1:0]   REGION_WIDTH  = '0,
  parameter int unsigned                BOOT_CYCLES   = 8,
  parameter int unsigned                BERR_TIMEOUT  = 64,
  parameter logic [6:0]                 VECTORED_MASK = 7'b0010000
) (
  input  logic                   CLK,
  input  logic                   RST,
  bus_cycle_controller_if.slave  bus,
  input  logic [6:0]             IRQ,
  output logic [NUM_REGIONS-1:0] CS_n,
  output logic [6:0]             IACK_n,
  output logic [2:0]             IPL_n,
  output logic                   BOOT
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_EXTACK = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam int unsigned BCW     = $clog2(BOOT_CYCLES + 1);
  localparam logic [7:0]  TO_LAST = 8'(BERR_TIMEOUT - 1);

  logic [2:0]             state;
  logic [15:0]            a_hi;
  logic [2:0]             lvl_q;
  logic [2:0]             fc_q;
  logic [3:0]             wcnt;
  logic [7:0]             tcnt;
  logic [BCW-1:0]         boot_cnt;
  logic [1:0]             width_q;
  logic                   avec_q;
  logic                   ack_seen;
  logic [1:0]             ext_q;

  logic                   is_cpu;
  logic                   is_iack;
  logic [6:0]             iack_onehot;
  logic                   lvl_vectored;
  logic                   hit;
  logic [NUM_REGIONS-1:0] cs_onehot;
  logic [3:0]             hit_wait;
  logic [1:0]             hit_width;
  logic [2:0]             ipl_lvl;
  logic                   timeout;

  assign bus.RD_n = ~( bus.RW & ~bus.AS_n & ~bus.DS_n);
  assign bus.WR_n = ~(~bus.RW & ~bus.AS_n & ~bus.DS_n);

  assign timeout = (tcnt == TO_LAST);

  always_comb begin
    is_cpu       = (fc_q == 3'd7);
    is_iack      = is_cpu && (a_hi[3:0] == 4'hF);
    iack_onehot  = (lvl_q == 3'd0) ? '0 : 7'(7'b1 << (lvl_q - 3'd1));
    lvl_vectored = |(iack_onehot & VECTORED_MASK);

    hit       = 1'b0;
    cs_onehot = '0;
    hit_wait  = '0;
    hit_width = '0;
    if (!BOOT) begin
      hit       = 1'b1;
      cs_onehot = NUM_REGIONS'(1);
      hit_wait  = REGION_WAIT[3:0];
      hit_width = REGION_WIDTH[1:0];
    end else begin
      // Ascending scan with a found flag: lowest matching index wins.
      for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
        if (!hit && ((a_hi & REGION_MASK[r*16 +: 16]) == REGION_BASE[r*16 +: 16])) begin
          hit       = 1'b1;
          cs_onehot = NUM_REGIONS'(1) << r;
          hit_wait  = REGION_WAIT[r*4 +: 4];
          hit_width = REGION_WIDTH[r*2 +: 2];
        end
      end
    end

    ipl_lvl = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (IRQ[i]) ipl_lvl = 3'(i + 1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      a_hi         <= '0;
      lvl_q        <= '0;
      fc_q         <= '0;
      wcnt         <= '0;
      tcnt         <= '0;
      boot_cnt     <= '0;
      width_q      <= '0;
      avec_q       <= 1'b0;
      ack_seen     <= 1'b0;
      ext_q        <= '1;
      BOOT         <= 1'b0;
      CS_n         <= '1;
      IACK_n       <= '1;
      IPL_n        <= '1;
      bus.DSACK0_n <= 1'b1;
      bus.DSACK1_n <= 1'b1;
      bus.BERR_n   <= 1'b1;
      bus.AVEC_n   <= 1'b1;
    end else begin
      ext_q <= bus.EXT_DSACK_n;
      IPL_n <= ~ipl_lvl;

      if (state != S_IDLE && bus.AS_n) begin
        // AS_n negated ends (or aborts) the cycle from any active state.
        state        <= S_IDLE;
        ack_seen     <= 1'b0;
        CS_n         <= '1;
        IACK_n       <= '1;
        bus.DSACK0_n <= 1'b1;
        bus.DSACK1_n <= 1'b1;
        bus.BERR_n   <= 1'b1;
        bus.AVEC_n   <= 1'b1;
        if (!BOOT && boot_cnt == BCW'(BOOT_CYCLES)) BOOT <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (!bus.AS_n) begin
              a_hi     <= bus.A[31:16];
              lvl_q    <= bus.A[3:1];
              fc_q     <= bus.FC;
              tcnt     <= '0;
              avec_q   <= 1'b0;
              ack_seen <= 1'b0;
              state    <= S_DECODE;
              if (!BOOT) boot_cnt <= boot_cnt + 1'b1;
            end
          end

          S_DECODE: begin
            tcnt <= tcnt + 1'b1;
            if (is_iack) begin
              if (lvl_vectored) begin
                IACK_n <= ~iack_onehot;
                state  <= S_EXTACK;
              end else if (lvl_q == 3'd0) begin
                // Level 0 is never a real interrupt acknowledge.
                state <= S_FAULT;
              end else begin
                avec_q <= 1'b1;
                state  <= S_ACK;
              end
            end else if (is_cpu) begin
              state <= S_FAULT;
            end else if (hit) begin
              CS_n    <= ~cs_onehot;
              wcnt    <= hit_wait;
              width_q <= hit_width;
              state   <= (hit_width == 2'd3) ? S_EXTACK : S_WAIT;
            end else begin
              state <= S_FAULT;
            end
          end

          S_WAIT: begin
            // DSACK is asserted on the transition so it lands W+2 edges after AS_n.
            if (wcnt == 4'd0) begin
              state        <= S_ACK;
              bus.DSACK0_n <= (width_q == 2'd1);
              bus.DSACK1_n <= (width_q == 2'd0);
            end else if (timeout) begin
              state      <= S_FAULT;
              bus.BERR_n <= 1'b0;
            end else begin
              wcnt <= wcnt - 1'b1;
              tcnt <= tcnt + 1'b1;
            end
          end

          S_EXTACK: begin
            bus.DSACK0_n <= ext_q[0];
            bus.DSACK1_n <= ext_q[1];
            if (ext_q != 2'b11) begin
              ack_seen <= 1'b1;
            end else if (!ack_seen) begin
              if (timeout) begin
                state        <= S_FAULT;
                bus.BERR_n   <= 1'b0;
                bus.DSACK0_n <= 1'b1;
                bus.DSACK1_n <= 1'b1;
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end
          end

          S_ACK: begin
            if (avec_q) bus.AVEC_n <= 1'b0;
          end

          S_FAULT: begin
            bus.BERR_n <= 1'b0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_controller.sv
module tb_bus_cycle_controller;
  localparam int T = 64;
  localparam int K_REG = 0, K_VEC = 1, K_AVEC = 2, K_FAULT = 3;

  typedef struct {
    int kind;
    int idx;
    int wt;
    int wd;
  } pred_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] IRQ;
  logic [3:0] CS_n;
  logic [6:0] IACK_n;
  logic [2:0] IPL_n;
  logic       BOOT;
  logic [15:0] obs;

  int total  = 0;
  int passed = 0;
  int started = 0;
  logic mboot = 1'b0;

  logic [15:0] rbase  [4] = '{16'hF000, 16'h0000, 16'h8000, 16'hC000};
  logic [15:0] rmask  [4] = '{16'hF000, 16'hF000, 16'hF000, 16'hF000};
  int          rwait  [4] = '{1, 2, 3, 0};
  int          rwidth [4] = '{0, 2, 1, 3};
  logic [6:0]  vecmask    = 7'b0010000;

  bus_cycle_controller_if bus ();

  bus_cycle_controller #(
    .NUM_REGIONS  (4),
    .REGION_BASE  (64'hC000_8000_0000_F000),
    .REGION_MASK  (64'hF000_F000_F000_F000),
    .REGION_WAIT  (16'h0321),
    .REGION_WIDTH (8'b11_01_10_00),
    .BOOT_CYCLES  (8),
    .BERR_TIMEOUT (T),
    .VECTORED_MASK(7'b0010000)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .bus   (bus),
    .IRQ   (IRQ),
    .CS_n  (CS_n),
    .IACK_n(IACK_n),
    .IPL_n (IPL_n),
    .BOOT  (BOOT)
  );

  always #5 CLK = ~CLK;

  assign obs = {BOOT, CS_n, IACK_n, bus.DSACK1_n, bus.DSACK0_n, bus.BERR_n, bus.AVEC_n};

  // Reference classification of a cycle from the address map rules.
  function automatic pred_t predict(logic [31:0] a, logic [2:0] fc, logic boot);
    pred_t p;
    int lvl;
    p.kind = K_FAULT; p.idx = 0; p.wt = 0; p.wd = 0;
    lvl = int'(a[3:1]);
    if (fc == 3'd7) begin
      if (a[19:16] == 4'hF && lvl != 0) begin
        p.idx  = lvl;
        p.kind = vecmask[lvl-1] ? K_VEC : K_AVEC;
      end
    end else begin
      for (int r = 3; r >= 0; r--) begin
        if (boot ? ((a[31:16] & rmask[r]) == rbase[r]) : (r == 0)) begin
          p.kind = K_REG; p.idx = r; p.wt = rwait[r]; p.wd = rwidth[r];
        end
      end
    end
    return p;
  endfunction

  // Expected outputs k edges after AS_n is first sampled low; the external
  // acknowledge value extv is applied right after edge d.
  function automatic logic [15:0] expect_out(pred_t p, int k, logic [1:0] extv, int d, logic boot);
    logic [3:0] cs;
    logic [6:0] ia;
    logic [1:0] ds;
    logic berr, avec;
    cs = 4'hF; ia = 7'h7F; ds = 2'b11; berr = 1'b1; avec = 1'b1;
    if (p.kind == K_REG && k >= 1) cs[p.idx] = 1'b0;
    if (p.kind == K_VEC && k >= 1) ia[p.idx-1] = 1'b0;
    if (p.kind == K_AVEC && k >= 2) avec = 1'b0;
    if (p.kind == K_FAULT && k >= 2) berr = 1'b0;
    if (p.kind == K_REG && p.wd != 3 && k >= 2 + p.wt)
      ds = (p.wd == 0) ? 2'b10 : (p.wd == 1) ? 2'b01 : 2'b00;
    if ((p.kind == K_VEC || (p.kind == K_REG && p.wd == 3))) begin
      if (k >= d + 2) ds = extv;
      if (extv == 2'b11 && k >= T) begin berr = 1'b0; ds = 2'b11; end
    end
    return {boot, cs, ia, ds, berr, avec};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_cycle(input logic [31:0] a, input logic [2:0] fc, input logic rw);
    bus.A = a; bus.FC = fc; bus.RW = rw;
    bus.AS_n = 1'b0; bus.DS_n = 1'b0; bus.EXT_DSACK_n = 2'b11;
    if (!mboot) started++;
  endtask

  task automatic end_cycle();
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.EXT_DSACK_n = 2'b11;
    step();
    if (!mboot && started >= 8) mboot = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; IRQ = '0;
    bus.A = '0; bus.FC = '0; bus.RW = 1'b1; bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    bus.EXT_DSACK_n = 2'b11;
    step(); step();
    total++; if (obs !== 16'h7FFF) $display("FAIL reset_outputs: got %h want %h", obs, 16'h7FFF); else passed++;
    total++; if (IPL_n !== 3'b111) $display("FAIL reset_ipl: got %b want 111", IPL_n); else passed++;
    RST = 1'b0; started = 0; mboot = 1'b0;
    step();
    total++; if (obs !== 16'h7FFF) $display("FAIL reset_idle: got %h want %h", obs, 16'h7FFF); else passed++;
  endtask

  task automatic test_boot_overlay();
    logic [4:0] e;
    for (int i = 0; i < 9; i++) begin
      begin_cycle(32'h0000_0000, 3'd5, 1'b1);
      step(); step();
      e = {(i >= 8), (i < 8) ? 4'b1110 : 4'b1101};
      total++; if ({BOOT, CS_n} !== e) $display("FAIL boot_cs[%0d]: got %b want %b", i, {BOOT, CS_n}, e); else passed++;
      repeat (4) step();
      end_cycle();
      total++; if (BOOT !== (i >= 7)) $display("FAIL boot_flag[%0d]: got %b want %b", i, BOOT, (i >= 7)); else passed++;
    end
  endtask

  task automatic test_wait_width();
    logic [15:0] e;
    begin_cycle(32'h8000_1234, 3'd5, 1'b1);
    for (int k = 0; k <= 5; k++) begin
      step();
      e = {1'b1, (k >= 1) ? 4'b1011 : 4'b1111, 7'h7F, (k >= 5) ? 2'b01 : 2'b11, 2'b11};
      total++; if (obs !== e) $display("FAIL wait16 k=%0d: got %h want %h", k, obs, e); else passed++;
    end
    end_cycle();
    total++; if (obs !== 16'hFFFF) $display("FAIL wait16_end: got %h want %h", obs, 16'hFFFF); else passed++;
  endtask

  task automatic test_unmapped();
    logic [15:0] e;
    begin_cycle(32'h5000_0000, 3'd5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      e = {1'b1, 4'hF, 7'h7F, 2'b11, (k >= 2) ? 1'b0 : 1'b1, 1'b1};
      total++; if (obs !== e) $display("FAIL unmapped k=%0d: got %h want %h", k, obs, e); else passed++;
    end
    end_cycle();
    total++; if (obs !== 16'hFFFF) $display("FAIL unmapped_end: got %h want %h", obs, 16'hFFFF); else passed++;
  endtask

  task automatic test_watchdog();
    logic [15:0] e;
    begin_cycle(32'hC000_0010, 3'd5, 1'b0);
    for (int k = 0; k <= 65; k++) begin
      step();
      e = {1'b1, (k >= 1) ? 4'b0111 : 4'b1111, 7'h7F, 2'b11, (k >= T) ? 1'b0 : 1'b1, 1'b1};
      if (k == 1 || k >= 63) begin
        total++; if (obs !== e) $display("FAIL watchdog k=%0d: got %h want %h", k, obs, e); else passed++;
      end
    end
    end_cycle();
    total++; if (obs !== 16'hFFFF) $display("FAIL watchdog_end: got %h want %h", obs, 16'hFFFF); else passed++;
  endtask

  task automatic test_iack();
    logic [15:0] e;
    begin_cycle(32'h000F_000A, 3'd7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      e = {1'b1, 4'hF, (k >= 1) ? 7'b1101111 : 7'h7F, (k >= 2) ? 2'b10 : 2'b11, 2'b11};
      total++; if (obs !== e) $display("FAIL iack_vec k=%0d: got %h want %h", k, obs, e); else passed++;
      if (k == 0) bus.EXT_DSACK_n = 2'b10;
    end
    end_cycle();
    total++; if (obs !== 16'hFFFF) $display("FAIL iack_vec_end: got %h want %h", obs, 16'hFFFF); else passed++;
    begin_cycle(32'h000F_0006, 3'd7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      e = {1'b1, 4'hF, 7'h7F, 2'b11, 1'b1, (k >= 2) ? 1'b0 : 1'b1};
      total++; if (obs !== e) $display("FAIL iack_avec k=%0d: got %h want %h", k, obs, e); else passed++;
    end
    end_cycle();
    total++; if (obs !== 16'hFFFF) $display("FAIL iack_avec_end: got %h want %h", obs, 16'hFFFF); else passed++;
  endtask

  task automatic test_cpu_space();
    logic [15:0] e;
    begin_cycle(32'h0002_0000, 3'd7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      e = {1'b1, 4'hF, 7'h7F, 2'b11, (k >= 2) ? 1'b0 : 1'b1, 1'b1};
      total++; if (obs !== e) $display("FAIL cpu_space k=%0d: got %h want %h", k, obs, e); else passed++;
    end
    end_cycle();
  endtask

  task automatic test_priority();
    logic [6:0] irq;
    logic [2:0] lvl;
    IRQ = 7'b0010100;
    #1;
    total++; if (IPL_n !== 3'b111) $display("FAIL ipl_latency: got %b want 111", IPL_n); else passed++;
    step();
    total++; if (IPL_n !== 3'b010) $display("FAIL ipl_fixed: got %b want 010", IPL_n); else passed++;
    for (int i = 0; i < 12; i++) begin
      irq = 7'($urandom);
      if (i == 0) irq = '0;
      IRQ = irq;
      step();
      lvl = 3'd0;
      for (int b = 6; b >= 0; b--) begin
        if (irq[b]) begin lvl = 3'(b + 1); break; end
      end
      total++; if (IPL_n !== ~lvl) $display("FAIL ipl_rand irq=%b: got %b want %b", irq, IPL_n, ~lvl); else passed++;
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a;
    logic [2:0]  fc;
    logic        rw, b;
    logic [1:0]  extv;
    logic [15:0] e;
    int          d;
    pred_t       p;
    logic [3:0]  nibs [5] = '{4'hF, 4'h0, 4'h8, 4'hC, 4'h5};
    logic [1:0]  exts [3] = '{2'b10, 2'b01, 2'b00};
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      a[31:28] = nibs[$urandom_range(0, 4)];
      fc = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      if (fc == 3'd7 && $urandom_range(0, 3) != 0) a[19:16] = 4'hF;
      rw   = 1'($urandom);
      extv = exts[$urandom_range(0, 2)];
      d    = int'($urandom_range(0, 3));
      b    = mboot;
      p    = predict(a, fc, b);
      begin_cycle(a, fc, rw);
      for (int k = 0; k < 8; k++) begin
        step();
        if (k == 0) begin
          total++;
          if ({bus.RD_n, bus.WR_n} !== {~rw, rw})
            $display("FAIL strobes rw=%b: got %b want %b", rw, {bus.RD_n, bus.WR_n}, {~rw, rw});
          else passed++;
        end
        e = expect_out(p, k, extv, d, b);
        total++;
        if (obs !== e) $display("FAIL rand_cycle a=%h fc=%0d k=%0d: got %h want %h", a, fc, k, obs, e);
        else passed++;
        if (k == d) bus.EXT_DSACK_n = extv;
      end
      end_cycle();
      e = {mboot, 15'h7FFF};
      total++; if (obs !== e) $display("FAIL rand_end a=%h: got %h want %h", a, obs, e); else passed++;
    end
  endtask

  task automatic test_reset_mid_cycle();
    begin_cycle(32'h8000_0000, 3'd5, 1'b1);
    step(); step(); step();
    total++; if (CS_n !== 4'b1011) $display("FAIL midrst_pre: got %b want 1011", CS_n); else passed++;
    RST = 1'b1;
    step();
    total++; if (obs !== 16'h7FFF) $display("FAIL midrst_outputs: got %h want %h", obs, 16'h7FFF); else passed++;
    total++; if (IPL_n !== 3'b111) $display("FAIL midrst_ipl: got %b want 111", IPL_n); else passed++;
    bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    RST = 1'b0; started = 0; mboot = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_boot_overlay();
    test_wait_width();
    test_unmapped();
    test_watchdog();
    test_iack();
    test_cpu_space();
    test_priority();
    test_random(40);
    test_reset_mid_cycle();
    test_random(14);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
